// File: rtl/radix5_digit_serializer_pkg.sv
// Shared constants and types for the radix-5 digit serializer.
//   X_W     : dividend width, fixed at 32 by the divide-by-5 core
//   Q_W     : quotient width produced by the divide-by-5 core
//   DIG_W   : width of one base-5 digit (0..4)
//   MAX_DIG : maximum digits per word (5^14 > 2^32-1)
//   IDX_W   : width of the digit index
package radix5_digit_serializer_pkg;

    localparam int unsigned X_W     = 32;
    localparam int unsigned Q_W     = 30;
    localparam int unsigned DIG_W   = 3;
    localparam int unsigned MAX_DIG = 14;
    localparam int unsigned IDX_W   = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // One emitted digit as seen on the output stream.
    typedef struct packed {
        logic [DIG_W-1:0] dig;
        logic [IDX_W-1:0] idx;
        logic             last;
    } digit_t;

endpackage

// File: rtl/radix5_digit_serializer_if.sv
// Word-in / digit-out stream bundle for the radix-5 serializer.
//   in_valid/in_ready/in_x             : 32-bit word input stream
//   dig_valid/dig_ready/dig/dig_idx/dig_last : digit output stream
// slave  = serializer side, master = source/sink side.
interface radix5_digit_serializer_if;
    import radix5_digit_serializer_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [X_W-1:0]   in_x;
    logic             dig_valid;
    logic             dig_ready;
    logic [DIG_W-1:0] dig;
    logic [IDX_W-1:0] dig_idx;
    logic             dig_last;

    modport slave (
        input  in_valid, in_x, dig_ready,
        output in_ready, dig_valid, dig, dig_idx, dig_last
    );

    modport master (
        output in_valid, in_x, dig_ready,
        input  in_ready, dig_valid, dig, dig_idx, dig_last
    );

endinterface

// File: rtl/radix5_digit_serializer_div.sv
// div_32_5: combinational unsigned divide of a 32-bit word by the constant 5.
//   i_x [31:0] : dividend
//   o_q [29:0] : quotient (2^32/5 < 2^30, so 30 bits suffice)
//   o_r [2:0]  : remainder 0..4
module div_32_5
    import radix5_digit_serializer_pkg::*;
(
    input  logic [X_W-1:0]   i_x,
    output logic [Q_W-1:0]   o_q,
    output logic [DIG_W-1:0] o_r
);

    logic [DIG_W:0]   w_t;
    logic [DIG_W-1:0] w_rem;

    // Restoring long division, one dividend bit per step. The top two bits
    // can never reach 5, so they seed the partial remainder directly.
    always_comb begin
        o_q   = '0;
        w_t   = '0;
        w_rem = {1'b0, i_x[X_W-1 -: 2]};
        for (int i = Q_W - 1; i >= 0; i--) begin
            w_t = {w_rem, i_x[i]};
            if (w_t >= 4'd5) begin
                o_q[i] = 1'b1;
                w_rem  = DIG_W'(w_t - 4'd5);
            end else begin
                o_q[i] = 1'b0;
                w_rem  = w_t[DIG_W-1:0];
            end
        end
        o_r = w_rem;
    end

endmodule

// File: rtl/radix5_digit_serializer.sv
// radix5_digit_serializer: emits the base-5 digits of a 32-bit word, LSD first,
// one digit per clock while the sink is ready. The divide-by-5 core is fed
// from the work register; its remainder is the current digit and its
// quotient becomes the next work value.
//   clk, rst_n : clock, asynchronous active-low reset
//   s_if       : stream bundle (slave modport) - word in, digit out
//   busy       : a word is in progress
// Build option: define RADIX5_SER_BACK2BACK_EN to accept the next word on the
// last-digit handshake (removes the idle cycle between words; in_ready then
// depends combinationally on dig_ready).
module radix5_digit_serializer
    import radix5_digit_serializer_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    radix5_digit_serializer_if.slave  s_if,
    output logic                      busy
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [X_W-1:0]   r_work;
    logic [X_W-1:0]   w_work_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;

    logic [Q_W-1:0]   w_q;
    logic [DIG_W-1:0] w_r;
    logic             w_dig_valid;
    logic             w_last;
    logic             w_dig_hs;
    logic             w_in_ready;
    logic             w_accept;

    div_32_5 u_div (
        .i_x (r_work),
        .o_q (w_q),
        .o_r (w_r)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_work  <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_work  <= w_work_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state, handshake and datapath update.
    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_idx_nxt   = r_idx;

        w_dig_valid = (r_state == ST_RUN);
        w_last      = w_dig_valid && (w_q == '0);
        w_dig_hs    = w_dig_valid && s_if.dig_ready;
`ifdef RADIX5_SER_BACK2BACK_EN
        w_in_ready  = (r_state == ST_IDLE) || (w_dig_hs && w_last);
`else
        w_in_ready  = (r_state == ST_IDLE);
`endif
        w_accept    = s_if.in_valid && w_in_ready;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_work_nxt  = s_if.in_x;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_dig_hs) begin
                    if (!w_last) begin
                        w_work_nxt = X_W'(w_q);
                        w_idx_nxt  = r_idx + IDX_W'(1);
                    end else if (w_accept) begin
                        // Back-to-back word: reload and keep running.
                        w_work_nxt = s_if.in_x;
                        w_idx_nxt  = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Digit fields are forced to zero outside RUN so idle outputs stay quiet.
    assign s_if.in_ready  = w_in_ready;
    assign s_if.dig_valid = w_dig_valid;
    assign s_if.dig       = w_dig_valid ? w_r : '0;
    assign s_if.dig_idx   = w_dig_valid ? r_idx : '0;
    assign s_if.dig_last  = w_last;
    assign busy           = (r_state == ST_RUN);

endmodule

// File: tb/tb_radix5_digit_serializer.sv
// Self-checking bench for radix5_digit_serializer: table of words with known
// digit counts / MSDs, scoreboard of model digits, hand-written stall,
// back-to-back and mid-word reset sequences, then random backpressure.
module tb_radix5_digit_serializer;
    import radix5_digit_serializer_pkg::*;

`ifdef RADIX5_SER_BACK2BACK_EN
    localparam int EXP_GAP = 1;
`else
    localparam int EXP_GAP = 2;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic busy;

    radix5_digit_serializer_if ifc ();

    radix5_digit_serializer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_if  (ifc.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    digit_t sb[$];
    digit_t mon_exp;
    digit_t held;
    logic   prev_stall = 1'b0;
    int words_done = 0, cur_digs = 0, word_digs = 0, last_dig = 0;
    int first_cyc = 0, last_cyc = 0, gap_obs = 0, acc_cyc = 0, stall_cycles = 0;

    // Sink-ready driver controls.
    logic rand_mode = 1'b0;
    logic stall_req = 1'b0;
    int   stall_idx = 0, stall_len = 0, stall_cnt = 0;

    typedef struct {
        logic [31:0] x;
        int          ndig;
        int          msd;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Software base-5 model: push expected digits of x.
    task automatic push_model(input logic [31:0] x);
        logic [31:0] v;
        int i;
        digit_t d;
        v = x;
        i = 0;
        do begin
            d.dig  = 3'(v % 5);
            v      = v / 5;
            d.idx  = 4'(i);
            d.last = (v == 0);
            sb.push_back(d);
            i++;
        end while (v != 0);
    endtask

    task automatic send_word(input logic [31:0] x);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        ifc.in_valid = 1'b1;
        ifc.in_x     = x;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ifc.in_ready) begin
                push_model(x);
                acc_cyc = cyc;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("accept_timeout");
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic wait_words(input int target);
        for (int i = 0; i < 400 && words_done < target; i++) @(negedge clk);
        #1;
        if (words_done < target) fail_now("word_done_timeout");
    endtask

    // Monitor: scoreboard pop on handshake, stall-stability and index range.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else if (ifc.dig_valid) begin
            chk("idx_range", 32'(ifc.dig_idx <= 4'(MAX_DIG - 1)), 1);
            if (prev_stall) begin
                chk("hold_dig",  ifc.dig,      held.dig);
                chk("hold_idx",  ifc.dig_idx,  held.idx);
                chk("hold_last", ifc.dig_last, held.last);
            end
            if (ifc.dig_ready) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_digit");
                end else begin
                    mon_exp = sb.pop_front();
                    chk("dig",      ifc.dig,      mon_exp.dig);
                    chk("dig_idx",  ifc.dig_idx,  mon_exp.idx);
                    chk("dig_last", ifc.dig_last, mon_exp.last);
                end
                if (ifc.dig_idx == 0) begin
                    first_cyc = cyc;
                    gap_obs   = cyc - last_cyc;
                    cur_digs  = 0;
                end
                cur_digs++;
                if (ifc.dig_last) begin
                    word_digs = cur_digs;
                    last_dig  = int'(ifc.dig);
                    last_cyc  = cyc;
                    words_done++;
                end
                prev_stall = 1'b0;
            end else begin
                prev_stall = 1'b1;
                held       = '{dig: ifc.dig, idx: ifc.dig_idx, last: ifc.dig_last};
                stall_cycles++;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Sink ready: targeted stall, random backpressure, or always ready.
    initial begin
        ifc.dig_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (stall_cnt > 0) begin
                ifc.dig_ready = 1'b0;
                stall_cnt--;
            end else if (stall_req && ifc.dig_valid && int'(ifc.dig_idx) == stall_idx) begin
                ifc.dig_ready = 1'b0;
                stall_cnt     = stall_len - 1;
                stall_req     = 1'b0;
            end else begin
                ifc.dig_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bit hit;
        tbl[0] = '{32'd0,          1,  0};
        tbl[1] = '{32'd123,        3,  4};
        tbl[2] = '{32'hFFFFFFFF,   14, 3};
        tbl[3] = '{32'd4,          1,  4};
        tbl[4] = '{32'd5,          2,  1};
        tbl[5] = '{32'd24,         2,  4};
        tbl[6] = '{32'd25,         3,  1};
        tbl[7] = '{32'd7,          2,  1};
        tbl[8] = '{32'd1220703125, 14, 1};
        tbl[9] = '{32'd1220703124, 13, 4};

        rst_n        = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_x     = '0;

        // Reset state.
        #12;
        chk("rst_dig_valid", ifc.dig_valid, 0);
        chk("rst_dig",       ifc.dig,       0);
        chk("rst_dig_idx",   ifc.dig_idx,   0);
        chk("rst_dig_last",  ifc.dig_last,  0);
        chk("rst_busy",      busy,          0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", ifc.in_ready, 1);

        // X=0: single zero digit, busy drops right after.
        t = words_done;
        send_word(32'd0);
        wait_words(t + 1);
        chk("zero_ndig", word_digs, 1);
        @(negedge clk);
        chk("zero_busy_after", busy, 0);

        // Table: digit count, MSD, one digit per cycle, latency 1.
        foreach (tbl[k]) begin
            t = words_done;
            send_word(tbl[k].x);
            wait_words(t + 1);
            chk("tbl_ndig",    word_digs,              tbl[k].ndig);
            chk("tbl_msd",     last_dig,               tbl[k].msd);
            chk("tbl_span",    last_cyc - first_cyc,   tbl[k].ndig - 1);
            chk("tbl_latency", first_cyc - acc_cyc,    1);
        end

        // Stall at idx 1 for 5 cycles.
        stall_cycles = 0;
        stall_idx    = 1;
        stall_len    = 5;
        stall_req    = 1'b1;
        t = words_done;
        send_word(32'd123);
        wait_words(t + 1);
        chk("stall_cycles", stall_cycles, 5);
        chk("stall_ndig",   word_digs,    3);

        // Second word offered while the first is running.
        t = words_done;
        send_word(32'd123);
        send_word(32'd7);
        wait_words(t + 2);
        chk("b2b_gap",  gap_obs,   EXP_GAP);
        chk("b2b_ndig", word_digs, 2);

        // Reset in the middle of a word.
        send_word(32'hFFFFFFFF);
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ifc.dig_valid && ifc.dig_idx == 4'd5) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) fail_now("reach_idx5_timeout");
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_dig_valid", ifc.dig_valid, 0);
        chk("midrst_busy",      busy,          0);
        sb.delete();
        @(posedge clk);
        @(posedge clk); #1;
        chk("midrst_dig_idx", ifc.dig_idx, 0);
        rst_n = 1'b1;
        t = words_done;
        send_word(32'd7);
        wait_words(t + 1);
        chk("postrst_ndig", word_digs, 2);
        chk("postrst_msd",  last_dig,  1);

        // Random words under random backpressure.
        rand_mode = 1'b1;
        for (int i = 0; i < 20; i++) begin
            t = words_done;
            send_word($urandom() >> $urandom_range(0, 31));
            wait_words(t + 1);
        end
        rand_mode = 1'b0;
        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
